// File: rtl/dcache_line_fill_ctrl.sv
// dcache_line_fill_ctrl: miss sequencer that writes back a dirty victim line, refills it and validates the tag
module dcache_line_fill_ctrl #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 32 - INDEX_BITS - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_hit,
  input  logic                  i_victim_dirty,
  input  logic [INDEX_BITS-1:0] i_index,
  input  logic [TAG_BITS-1:0]   i_req_tag,
  input  logic [TAG_BITS-1:0]   i_victim_tag,
  input  logic [127:0]          i_line_rdata,
  output logic                  o_stall,
  output logic [INDEX_BITS-1:0] o_col_index,
  output logic [3:0]            o_col_we,
  output logic [31:0]           o_fill_data,
  output logic                  o_tag_we,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;
  state_t                state;
  logic [1:0]            cnt;
  logic [INDEX_BITS-1:0] idx_r;
  logic [TAG_BITS-1:0]   req_tag_r;
  logic [TAG_BITS-1:0]   vic_tag_r;
  logic                  miss;
  logic                  wb;
  logic                  fill;
  assign miss = i_req && !i_hit;
  assign wb   = state == WRITEBACK;
  assign fill = state == FILL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      idx_r     <= '0;
      req_tag_r <= '0;
      vic_tag_r <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          idx_r     <= i_index;
          req_tag_r <= i_req_tag;
          vic_tag_r <= i_victim_tag;
          cnt       <= 2'd0;
          state     <= i_victim_dirty ? WRITEBACK : FILL;
        end
        WRITEBACK: if (i_mem_ack) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= FILL;
        end
        FILL: if (i_mem_ack) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_stall     = (state == IDLE) ? miss : 1'b1;
  assign o_col_index = (state == IDLE) ? i_index : idx_r;
  assign o_mem_req   = wb || fill;
  assign o_mem_we    = wb;
  assign o_mem_addr  = wb ? {vic_tag_r, idx_r, cnt, 2'b00} : fill ? {req_tag_r, idx_r, cnt, 2'b00} : 32'd0;
  assign o_mem_wdata = wb ? i_line_rdata[{cnt, 5'd0} +: 32] : 32'd0;
  assign o_col_we    = (fill && i_mem_ack) ? (4'b0001 << cnt) : 4'b0000;
  assign o_fill_data = (fill && i_mem_ack) ? i_mem_rdata : 32'd0;
  assign o_tag_we    = state == DONE;
endmodule

// File: tb/tb_dcache_line_fill_ctrl.sv
// tb_dcache_line_fill_ctrl: directed self-checking bench for the line fill controller
module tb_dcache_line_fill_ctrl;
  localparam int IB = 3;
  localparam int TB = 32 - IB - 4;
  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic          i_hit;
  logic          i_victim_dirty;
  logic [IB-1:0] i_index;
  logic [TB-1:0] i_req_tag;
  logic [TB-1:0] i_victim_tag;
  logic [127:0]  i_line_rdata;
  logic          o_stall;
  logic [IB-1:0] o_col_index;
  logic [3:0]    o_col_we;
  logic [31:0]   o_fill_data;
  logic          o_tag_we;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [31:0]   o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_ack;
  logic [31:0]   i_mem_rdata;
  int            checks = 0;
  int            errors = 0;
  int            stall_cyc;
  always #5 clk = ~clk;
  dcache_line_fill_ctrl #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_hit(i_hit), .i_victim_dirty(i_victim_dirty),
    .i_index(i_index), .i_req_tag(i_req_tag), .i_victim_tag(i_victim_tag), .i_line_rdata(i_line_rdata),
    .o_stall(o_stall), .o_col_index(o_col_index), .o_col_we(o_col_we), .o_fill_data(o_fill_data),
    .o_tag_we(o_tag_we), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic smp;
    @(negedge clk);
    stall_cyc += int'(o_stall);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] ba(input logic [TB-1:0] t, input logic [IB-1:0] ix, input logic [1:0] k);
    return {t, ix, k, 2'b00};
  endfunction
  task automatic start_miss(input logic [TB-1:0] t, input logic [TB-1:0] vt, input logic [IB-1:0] ix, input logic dirty);
    stall_cyc = 0;
    i_req = 1'b1; i_hit = 1'b0; i_victim_dirty = dirty;
    i_index = ix; i_req_tag = t; i_victim_tag = vt; i_mem_ack = 1'b0;
    smp;
    check("miss_stall", 32'(o_stall), 32'd1);
    check("miss_noreq", 32'(o_mem_req), 32'd0);
    tick;
  endtask
  task automatic wb_beat(input logic [TB-1:0] t, input logic [IB-1:0] ix, input logic [1:0] k,
                         input logic [31:0] d, input int waits, input logic tog);
    for (int w = 0; w <= waits; w++) begin
      i_mem_ack = (w == waits);
      if (tog) i_index = i_index + 3'd3;
      smp;
      check("wb_req", 32'(o_mem_req), 32'd1);
      check("wb_we", 32'(o_mem_we), 32'd1);
      check("wb_addr", o_mem_addr, ba(t, ix, k));
      check("wb_data", o_mem_wdata, d);
      check("wb_colwe", 32'(o_col_we), 32'd0);
      check("wb_colidx", 32'(o_col_index), 32'(ix));
      tick;
    end
  endtask
  task automatic fill_beat(input logic [TB-1:0] t, input logic [IB-1:0] ix, input logic [1:0] k,
                           input logic [31:0] d, input int waits, input logic tog);
    for (int w = 0; w <= waits; w++) begin
      i_mem_ack = (w == waits);
      i_mem_rdata = i_mem_ack ? d : 32'hDEAD_0000 | 32'(w);
      if (tog) i_index = i_index + 3'd3;
      smp;
      check("fill_req", 32'(o_mem_req), 32'd1);
      check("fill_we", 32'(o_mem_we), 32'd0);
      check("fill_addr", o_mem_addr, ba(t, ix, k));
      check("fill_colwe", 32'(o_col_we), i_mem_ack ? 32'(4'b0001 << k) : 32'd0);
      if (i_mem_ack) check("fill_data", o_fill_data, d);
      check("fill_colidx", 32'(o_col_index), 32'(ix));
      tick;
    end
  endtask
  task automatic done_release(input logic [IB-1:0] ix, input int exp_stall);
    i_mem_ack = 1'b0;
    smp;
    check("done_tagwe", 32'(o_tag_we), 32'd1);
    check("done_stall", 32'(o_stall), 32'd1);
    check("done_noreq", 32'(o_mem_req), 32'd0);
    check("done_colidx", 32'(o_col_index), 32'(ix));
    tick;
    i_hit = 1'b1;
    smp;
    check("rel_stall", 32'(o_stall), 32'd0);
    check("rel_tagwe", 32'(o_tag_we), 32'd0);
    check("stall_len", 32'(stall_cyc), 32'(exp_stall));
    tick;
  endtask
  initial begin
    rst = 1'b1; i_req = 1'b0; i_hit = 1'b0; i_victim_dirty = 1'b0; i_index = 3'd5;
    i_req_tag = '0; i_victim_tag = '0; i_line_rdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    stall_cyc = 0;
    @(negedge clk);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_req", 32'(o_mem_req), 32'd0);
    check("rst_addr", o_mem_addr, 32'd0);
    check("rst_colwe", 32'(o_col_we), 32'd0);
    check("rst_tagwe", 32'(o_tag_we), 32'd0);
    check("rst_colidx", 32'(o_col_index), 32'd5);
    tick;
    rst = 1'b0;
    i_req = 1'b1; i_hit = 1'b1; i_mem_ack = 1'b1;
    smp;
    check("hit_stall", 32'(o_stall), 32'd0);
    check("hit_noreq", 32'(o_mem_req), 32'd0);
    tick;
    i_req = 1'b0; i_mem_ack = 1'b0;
    smp;
    check("hit_idle_req", 32'(o_mem_req), 32'd0);
    check("hit_idle_stall", 32'(o_stall), 32'd0);
    tick;
    start_miss(25'h1234, 25'h0, 3'd5, 1'b0);
    for (int k = 0; k < 4; k++) fill_beat(25'h1234, 3'd5, 2'(k), 32'hA0 + 32'(k), 0, 1'b0);
    done_release(3'd5, 6);
    i_line_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
    start_miss(25'h1234, 25'h0FF, 3'd5, 1'b1);
    for (int k = 0; k < 4; k++) wb_beat(25'h0FF, 3'd5, 2'(k), 32'h11 * (32'(k) + 1), 0, 1'b0);
    for (int k = 0; k < 4; k++) fill_beat(25'h1234, 3'd5, 2'(k), 32'hB0 + 32'(k), 0, 1'b0);
    done_release(3'd5, 10);
    i_line_rdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    start_miss(25'h0ABC, 25'h0123, 3'd2, 1'b1);
    for (int k = 0; k < 4; k++) wb_beat(25'h0123, 3'd2, 2'(k), 32'hCAFE_0000 + 32'(k), 3, 1'b1);
    for (int k = 0; k < 4; k++) fill_beat(25'h0ABC, 3'd2, 2'(k), 32'hC0 + 32'(k), 3, 1'b1);
    done_release(3'd2, 34);
    start_miss(25'h55, 25'h0, 3'd3, 1'b0);
    for (int k = 0; k < 2; k++) fill_beat(25'h55, 3'd3, 2'(k), 32'hD0 + 32'(k), 0, 1'b0);
    i_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hD2; i_index = 3'd6;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(o_mem_req), 32'd0);
    check("arst_colwe", 32'(o_col_we), 32'd0);
    check("arst_stall", 32'(o_stall), 32'd0);
    check("arst_addr", o_mem_addr, 32'd0);
    check("arst_colidx", 32'(o_col_index), 32'd6);
    @(negedge clk);
    check("arst_tagwe", 32'(o_tag_we), 32'd0);
    tick;
    rst = 1'b0; i_mem_ack = 1'b0;
    smp;
    check("post_rst_tagwe", 32'(o_tag_we), 32'd0);
    check("post_rst_req", 32'(o_mem_req), 32'd0);
    tick;
    start_miss(25'h77, 25'h0, 3'd3, 1'b0);
    for (int k = 0; k < 4; k++) fill_beat(25'h77, 3'd3, 2'(k), 32'hE0 + 32'(k), 0, 1'b0);
    done_release(3'd3, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_line_fill_ctrl.md
Name: dcache_line_fill_ctrl

Overview:
- Miss-handling sequencer for the data cache's four per-offset data columns (one 32-bit word per column, 4 words per line).
- On a core miss it stalls the core and, if the victim line is dirty, writes it back word by word. It then refills the line from memory, driving the columns' memory-side write enables one column per beat.
- It validates the tag entry when the refill completes, and sits between the cache datapath and the memory bus.

Parameters:
- INDEX_BITS, 3, set-index width; must match the data columns.
- TAG_BITS, 32-INDEX_BITS-4, tag width. Address = {tag, index, word[1:0], byte[1:0]}.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  core load/store valid this cycle
- i_hit  in  1  tag compare hit for i_req (valid && tag match)
- i_victim_dirty  in  1  dirty bit of the indexed line
- i_index  in  INDEX_BITS  set index of core access
- i_req_tag  in  TAG_BITS  tag of core address
- i_victim_tag  in  TAG_BITS  tag currently stored at i_index
- i_line_rdata  in  128  concatenated column outputs, word k at [32k+31:32k]
- o_stall  out  1  hold core pipeline
- o_col_index  out  INDEX_BITS  index driven to columns while busy
- o_col_we  out  4  per-column memory-side write enable (one-hot or zero)
- o_fill_data  out  32  data to columns' memory-side write port
- o_tag_we  out  1  write {valid=1, dirty=0, tag=latched req tag} at o_col_index
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  1 = write-back beat, 0 = read beat
- o_mem_addr  out  32  word-aligned beat address
- o_mem_wdata  out  32  write-back data
- i_mem_ack  in  1  one-cycle beat completion
- i_mem_rdata  in  32  read data, valid with i_mem_ack

Behaviour:
- States: IDLE, WRITEBACK, FILL, DONE. A 2-bit beat counter cnt is paired with latched idx_r, req_tag_r and vic_tag_r.
- Reset: state=IDLE, cnt=0, latches=0.
  - All outputs deassert to 0. o_col_index = i_index in IDLE.
  - Reset mid-operation abandons the transfer. o_tag_we has not fired, so a partially refilled line stays invalid.
- IDLE:
  - o_stall = i_req && !i_hit (combinational, same cycle as the miss).
  - On a miss: latch idx_r, req_tag_r and vic_tag_r; set cnt=0.
  - Next state is WRITEBACK if i_victim_dirty, else FILL.
  - Hits and no-request cycles leave the controller in IDLE.
- WRITEBACK:
  - o_stall=1, o_mem_req=1, o_mem_we=1.
  - o_mem_addr = {vic_tag_r, idx_r, cnt, 2'b00}; o_mem_wdata = i_line_rdata word cnt.
  - Address and data are held stable until i_mem_ack.
  - On ack: cnt++. When ack arrives with cnt==3, cnt wraps to 0 and the state goes to FILL.
- FILL:
  - o_stall=1, o_mem_req=1, o_mem_we=0.
  - o_mem_addr = {req_tag_r, idx_r, cnt, 2'b00}.
  - On ack: o_col_we[cnt]=1 in the same cycle, o_fill_data = i_mem_rdata (combinational pass-through), cnt++.
  - When ack arrives with cnt==3, the state goes to DONE.
  - o_col_we=0 whenever i_mem_ack=0.
- DONE (one cycle): o_stall=1, o_tag_we=1, o_mem_req=0, then IDLE.
  - The core re-presents its access in IDLE and hits.
  - Miss-to-release latency with zero-wait memory: 1 (+4 if dirty) + 4 + 1 cycles.
- o_col_index = idx_r in every state except IDLE, so a core index change while stalled has no effect.
- Core stores are not arbitrated here. The core-side enable is masked by o_stall upstream, so the memory-side and core-side writes never coincide.
- i_mem_ack is ignored while o_mem_req=0.
- Memory address bits [1:0] are always 0.

Test Plan:
- Clean miss, INDEX 5, req_tag 0x1234, memory returning 0xA0..0xA3 with ack every cycle -> 4 read beats at word offsets 0,1,2,3; o_col_we 0001,0010,0100,1000; o_tag_we in cycle 6; o_stall high for 6 cycles.
- Dirty miss, victim_tag 0x0FF, line words 0x11/22/33/44 -> 4 write beats with o_mem_we=1, addresses {0x0FF,5,k,00}, data in order, followed by 4 read beats; total stall 10 cycles.
- Hit (i_req=1, i_hit=1) -> o_stall=0, no o_mem_req, state stays IDLE.
- Memory wait states, 3 idle cycles before each ack -> o_mem_addr/o_mem_wdata stable throughout; o_col_we only on ack cycles; cnt advances only on ack.
- rst asserted after 2 fill beats -> all outputs 0 immediately; o_tag_we never pulses; a following miss restarts at cnt=0.
- i_index toggled while stalled -> o_col_index and beat addresses keep the latched index.
